uart_tx_fifo_sb_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_core.sv | 137 +++++++++++++
 rtl/uart_tx_fifo_sb_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo_sb_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets, serializer
// state encoding and the frame parity helper.
package uart_pkg;

    localparam logic [31:0] UART_DATA  = 32'h0000_0000;
    localparam logic [31:0] UART_LEVEL = 32'h0000_0004;
    localparam logic [31:0] UART_BUSY  = 32'h0000_0008;
    localparam logic [31:0] UART_DIV   = 32'h0000_000C;
    localparam logic [31:0] UART_PAR   = 32'h0000_0010;
    localparam logic [31:0] UART_STOP  = 32'h0000_0014;
    localparam logic [31:0] UART_DBITS = 32'h0000_0018;
    localparam logic [31:0] UART_IRQ   = 32'h0000_001C;
    localparam logic [31:0] UART_STAT  = 32'h0000_0020;
    localparam logic [31:0] UART_RST   = 32'h0000_0024;

    // Frames carry DATA_BITS_BASE + data_bits payload bits.
    localparam int unsigned DATA_BITS_BASE = 5;
    localparam logic [19:0] MIN_DIV        = 20'd2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    // Even parity over only the bits that will actually be sent.
    function automatic logic even_parity(input logic [7:0] data, input logic [1:0] data_bits);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - data_bits);
        return ^(data & mask);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and
// extra-MSB pointers for the full/empty distinction.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read and write pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else if (srst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + (AW+1)'(1);
            end
        end
    end

    assign rdata = mem_r[rptr_r[AW-1:0]];
    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign level = wptr_r - rptr_r;

endmodule

// File: rtl/uart_tx_core.sv
// Serializer: start, LSB-first data, optional even parity, 1-2 stop bits.
// Frame configuration is captured when the byte is popped.
module uart_tx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    input  logic [19:0] divisor,
    input  logic        parity_en,
    input  logic        stopbits,
    input  logic [1:0]  data_bits,
    output logic        fifo_pop,
    output logic        active,
    output logic        tx
);

    uart_tx_state_t state_r;
    logic [19:0]    cnt_r;
    logic [19:0]    div_r;
    logic [7:0]     shift_r;
    logic [2:0]     bit_idx_r;
    logic [2:0]     last_idx_r;
    logic           par_en_r;
    logic           par_bit_r;
    logic           two_stop_r;
    logic           stop_idx_r;
    logic           tx_r;
    logic           active_r;
    logic           bit_end_s;
    logic           frame_end_s;
    logic           load_s;

    // Bit timing and next-byte fetch; a load at frame end gives gapless frames.
    always_comb begin
        bit_end_s   = (cnt_r == div_r - 20'd1);
        frame_end_s = (state_r == STOP) && bit_end_s && (!two_stop_r || stop_idx_r);
        load_s      = !fifo_empty && ((state_r == IDLE) || frame_end_s);
    end

    // Frame sequencer with registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 20'd0;
            div_r      <= MIN_DIV;
            shift_r    <= 8'd0;
            bit_idx_r  <= 3'd0;
            last_idx_r <= 3'd0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            two_stop_r <= 1'b0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
            active_r   <= 1'b0;
        end else if (srst) begin
            state_r    <= IDLE;
            cnt_r      <= 20'd0;
            div_r      <= MIN_DIV;
            shift_r    <= 8'd0;
            bit_idx_r  <= 3'd0;
            last_idx_r <= 3'd0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            two_stop_r <= 1'b0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
            active_r   <= 1'b0;
        end else if (load_s) begin
            state_r    <= START;
            cnt_r      <= 20'd0;
            div_r      <= divisor;
            shift_r    <= fifo_rdata;
            last_idx_r <= 3'(DATA_BITS_BASE - 1) + {1'b0, data_bits};
            par_en_r   <= parity_en;
            par_bit_r  <= even_parity(fifo_rdata, data_bits);
            two_stop_r <= stopbits;
            tx_r       <= 1'b0;
            active_r   <= 1'b1;
        end else if (state_r == IDLE) begin
            tx_r     <= 1'b1;
            active_r <= 1'b0;
        end else if (!bit_end_s) begin
            cnt_r <= cnt_r + 20'd1;
        end else begin
            cnt_r <= 20'd0;
            case (state_r)
                START: begin
                    state_r   <= DATA;
                    tx_r      <= shift_r[0];
                    shift_r   <= {1'b0, shift_r[7:1]};
                    bit_idx_r <= 3'd0;
                end
                DATA: begin
                    if (bit_idx_r != last_idx_r) begin
                        bit_idx_r <= bit_idx_r + 3'd1;
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[7:1]};
                    end else if (par_en_r) begin
                        state_r <= PARITY;
                        tx_r    <= par_bit_r;
                    end else begin
                        state_r    <= STOP;
                        tx_r       <= 1'b1;
                        stop_idx_r <= 1'b0;
                    end
                end
                PARITY: begin
                    state_r    <= STOP;
                    tx_r       <= 1'b1;
                    stop_idx_r <= 1'b0;
                end
                STOP: begin
                    if (two_stop_r && !stop_idx_r) begin
                        stop_idx_r <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        tx_r     <= 1'b1;
                        active_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tx_r     <= 1'b1;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_pop = load_s;
    assign active   = active_r;
    assign tx       = tx_r;

endmodule

// File: rtl/uart_tx_fifo_sb_ctrl.sv
// System-bus UART transmitter: register file, bus decode, soft reset,
// TX FIFO and serializer.
module uart_tx_fifo_sb_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int DEF_BAUD   = 9600
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        irq_o,
    output logic        tx_o
);

    localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [19:0] DEF_DIV = 20'(CLK_FREQ / DEF_BAUD);

    logic          wr_s, rd_s, busy_s, cfg_we_s, push_req_s, ovf_set_s;
    logic          fifo_pop_s, fifo_full_s, fifo_empty_s, core_active_s;
    logic [LW-1:0] fifo_level_s;
    logic [7:0]    fifo_rdata_s;
    logic [31:0]   rdata_s;
    logic          unused_s;
    logic [19:0]   divisor_r;
    logic          parity_en_r, stopbits_r, irq_en_r, overflow_r, srst_r;
    logic [1:0]    data_bits_r;
    logic [5:0]    threshold_r;
    logic [31:0]   read_data_r;

    // Bus decode; configuration that shapes frames is frozen while busy.
    always_comb begin
        wr_s       = req_i & write_enable_i;
        rd_s       = req_i & ~write_enable_i;
        busy_s     = core_active_s | ~fifo_empty_s;
        cfg_we_s   = wr_s & ~busy_s;
        push_req_s = wr_s & (addr_i == UART_DATA);
        ovf_set_s  = push_req_s & fifo_full_s & ~fifo_pop_s;
        unused_s   = ^write_data_i[31:20];
    end

    // Read multiplexer
    always_comb begin
        rdata_s = 32'd0;
        case (addr_i)
            UART_LEVEL: rdata_s = 32'(fifo_level_s);
            UART_BUSY:  rdata_s = {31'd0, busy_s};
            UART_DIV:   rdata_s = {12'd0, divisor_r};
            UART_PAR:   rdata_s = {31'd0, parity_en_r};
            UART_STOP:  rdata_s = {31'd0, stopbits_r};
            UART_DBITS: rdata_s = {30'd0, data_bits_r};
            UART_IRQ:   rdata_s = {18'd0, threshold_r, 7'd0, irq_en_r};
            UART_STAT:  rdata_s = {29'd0, fifo_full_s, fifo_empty_s, overflow_r};
            default:    rdata_s = 32'd0;
        endcase
    end

    // Configuration and status registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            divisor_r   <= DEF_DIV;
            parity_en_r <= 1'b1;
            stopbits_r  <= 1'b0;
            data_bits_r <= 2'd3;
            irq_en_r    <= 1'b0;
            threshold_r <= 6'd0;
            overflow_r  <= 1'b0;
        end else if (srst_r) begin
            divisor_r   <= DEF_DIV;
            parity_en_r <= 1'b1;
            stopbits_r  <= 1'b0;
            data_bits_r <= 2'd3;
            irq_en_r    <= 1'b0;
            threshold_r <= 6'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (cfg_we_s && (addr_i == UART_DIV)) begin
                divisor_r <= (write_data_i[19:0] < MIN_DIV) ? MIN_DIV : write_data_i[19:0];
            end
            if (cfg_we_s && (addr_i == UART_PAR)) begin
                parity_en_r <= write_data_i[0];
            end
            if (cfg_we_s && (addr_i == UART_STOP)) begin
                stopbits_r <= write_data_i[0];
            end
            if (cfg_we_s && (addr_i == UART_DBITS)) begin
                data_bits_r <= write_data_i[1:0];
            end
            if (wr_s && (addr_i == UART_IRQ)) begin
                irq_en_r    <= write_data_i[0];
                threshold_r <= write_data_i[13:8];
            end
            if (wr_s && (addr_i == UART_STAT)) begin
                overflow_r <= 1'b0;
            end else if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Soft-reset pulse and read data; read data survives the soft reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            srst_r      <= 1'b0;
            read_data_r <= 32'd0;
        end else begin
            srst_r <= wr_s && (addr_i == UART_RST) && write_data_i[0];
            if (rd_s) begin
                read_data_r <= rdata_s;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .srst  (srst_r),
        .push  (push_req_s),
        .pop   (fifo_pop_s),
        .wdata (write_data_i[7:0]),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    uart_tx_core u_core (
        .clk        (clk_i),
        .rst_n      (rstn_i),
        .srst       (srst_r),
        .fifo_empty (fifo_empty_s),
        .fifo_rdata (fifo_rdata_s),
        .divisor    (divisor_r),
        .parity_en  (parity_en_r),
        .stopbits   (stopbits_r),
        .data_bits  (data_bits_r),
        .fifo_pop   (fifo_pop_s),
        .active     (core_active_s),
        .tx         (tx_o)
    );

    assign read_data_o = read_data_r;
    assign irq_o       = irq_en_r & (32'(fifo_level_s) <= 32'(threshold_r));

endmodule

// File: tb/tb_uart_tx_fifo_sb_ctrl.sv
// Self-checking bench: every tx_o cycle is logged and compared with frames
// built from the line-protocol rules by a queue-based model.
module tb_uart_tx_fifo_sb_ctrl;

    localparam int          DEPTH   = 8;
    localparam int          DEF_DIV = 10_000_000 / 9600;
    localparam logic [31:0] A_DATA  = 32'h00, A_LEVEL = 32'h04, A_BUSY = 32'h08;
    localparam logic [31:0] A_DIV   = 32'h0C, A_PAR   = 32'h10, A_STOP = 32'h14;
    localparam logic [31:0] A_DBITS = 32'h18, A_IRQ   = 32'h1C, A_STAT = 32'h20;
    localparam logic [31:0] A_RST   = 32'h24;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic        req_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [31:0] write_data_i = 32'd0;
    logic [31:0] read_data_o;
    logic        irq_o;
    logic        tx_o;

    int   total = 0;
    int   bad = 0;
    int   last_widx = 0;
    logic txlog[$];
    logic exp_wave[$];

    uart_tx_fifo_sb_ctrl #(
        .CLK_FREQ   (10_000_000),
        .FIFO_DEPTH (DEPTH),
        .DEF_BAUD   (9600)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .addr_i         (addr_i),
        .req_i          (req_i),
        .write_enable_i (write_enable_i),
        .write_data_i   (write_data_i),
        .read_data_o    (read_data_o),
        .irq_o          (irq_o),
        .tx_o           (tx_o)
    );

    always #5 clk = ~clk;

    // Line log: entry k is the tx_o level during the cycle after posedge k.
    always @(posedge clk) begin
        #2;
        txlog.push_back(tx_o);
    end

    // Reference frame: start, LSB-first payload, even parity, stop bit(s).
    task automatic model_frame(input logic [7:0] b, input int div, input bit par,
                               input bit two_stop, input int dbits);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 5 + dbits; i++) begin
            bits.push_back(b[i]);
            ones = ones + int'(b[i]);
        end
        if (par) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        if (two_stop) bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int k = 0; k < div; k++) exp_wave.push_back(bits[j]);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
        @(posedge clk);
        #1;
        last_widx = txlog.size();
        req_i = 1'b0; write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        d = read_data_o;
    endtask

    task automatic wait_log(input int need, input int budget);
        int k;
        k = 0;
        while (txlog.size() < need && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        if (txlog.size() < need) begin
            total++; bad++;
            $display("FAIL wait_log: got %0d samples, need %0d", txlog.size(), need);
        end
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] d;
        int k;
        k = 0;
        bus_read(A_BUSY, d);
        while (d !== 32'd0 && k < budget) begin
            repeat (50) @(posedge clk);
            bus_read(A_BUSY, d);
            k++;
        end
        if (d !== 32'd0) begin
            total++; bad++;
            $display("FAIL wait_idle: busy=%0d after %0d polls, need 0", d, k);
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [10] = '{A_DIV, A_DBITS, A_STAT, A_PAR, A_STOP, A_IRQ, A_LEVEL, A_BUSY, 32'h28, A_DATA};
        logic [31:0] exps  [10] = '{32'(DEF_DIV), 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        total++; if (read_data_o !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", read_data_o); end
        @(negedge clk);
        rstn_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_read(addrs[i], d);
            total++;
            if (d !== exps[i]) begin bad++; $display("FAIL reset_reg %h: got %0d want %0d", addrs[i], d, exps[i]); end
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        int st;
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL div_clamp: got %0d want 2", d); end
        bus_write(A_DIV, 32'd4);
        bus_write(A_PAR, 32'd1);
        bus_write(A_STOP, 32'd0);
        bus_write(A_DBITS, 32'd3);
        exp_wave.delete();
        model_frame(8'hA5, 4, 1'b1, 1'b0, 3);
        bus_write(A_DATA, 32'h0000_00A5);
        st = last_widx + 1;
        bus_read(A_BUSY, d);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL single_busy: got %0d want 1", d); end
        wait_log(st + exp_wave.size() + 1, 300);
        total++; if (txlog[st-1] !== 1'b1) begin bad++; $display("FAIL single_pop_cycle: got %b want 1", txlog[st-1]); end
        for (int i = 0; i < exp_wave.size(); i++) begin
            total++;
            if (txlog[st+i] !== exp_wave[i]) begin bad++; $display("FAIL single_wave[%0d]: got %b want %b", i, txlog[st+i], exp_wave[i]); end
        end
        total++; if (txlog[st+44] !== 1'b1) begin bad++; $display("FAIL single_tail: got %b want 1", txlog[st+44]); end
        bus_read(A_BUSY, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL single_idle: busy=%0d want 0", d); end
    endtask

    task automatic test_back_to_back();
        int st;
        wait_idle(100);
        bus_write(A_DIV, 32'd3);
        bus_write(A_PAR, 32'd0);
        bus_write(A_STOP, 32'd1);
        bus_write(A_DBITS, 32'd2);
        exp_wave.delete();
        model_frame(8'h41, 3, 1'b0, 1'b1, 2);
        model_frame(8'h42, 3, 1'b0, 1'b1, 2);
        bus_write(A_DATA, 32'h41);
        st = last_widx + 1;
        bus_write(A_DATA, 32'h42);
        wait_log(st + exp_wave.size() + 1, 300);
        total++; if (txlog[st+29] !== 1'b1) begin bad++; $display("FAIL b2b_last_stop: got %b want 1", txlog[st+29]); end
        total++; if (txlog[st+30] !== 1'b0) begin bad++; $display("FAIL b2b_second_start: got %b want 0", txlog[st+30]); end
        for (int i = 0; i < exp_wave.size(); i++) begin
            total++;
            if (txlog[st+i] !== exp_wave[i]) begin bad++; $display("FAIL b2b_wave[%0d]: got %b want %b", i, txlog[st+i], exp_wave[i]); end
        end
        total++; if (txlog[st+60] !== 1'b1) begin bad++; $display("FAIL b2b_tail: got %b want 1", txlog[st+60]); end
    endtask

    task automatic test_random();
        int st, div, db, nb;
        bit par, ts;
        logic [7:0] b;
        for (int it = 0; it < 4; it++) begin
            wait_idle(100);
            div = $urandom_range(2, 5);
            db  = $urandom_range(0, 3);
            par = 1'($urandom_range(0, 1));
            ts  = 1'($urandom_range(0, 1));
            nb  = $urandom_range(1, 3);
            bus_write(A_DIV, 32'(div));
            bus_write(A_PAR, {31'd0, par});
            bus_write(A_STOP, {31'd0, ts});
            bus_write(A_DBITS, 32'(db));
            exp_wave.delete();
            st = 0;
            for (int n = 0; n < nb; n++) begin
                b = 8'($urandom_range(0, 255));
                model_frame(b, div, par, ts, db);
                bus_write(A_DATA, {24'd0, b});
                if (n == 0) st = last_widx + 1;
            end
            wait_log(st + exp_wave.size() + 1, 500);
            for (int i = 0; i < exp_wave.size(); i++) begin
                total++;
                if (txlog[st+i] !== exp_wave[i]) begin
                    bad++;
                    $display("FAIL rand%0d_wave[%0d]: got %b want %b (div=%0d db=%0d par=%0d stop2=%0d)",
                             it, i, txlog[st+i], exp_wave[i], div, db, par, ts);
                end
            end
            total++;
            if (txlog[st+exp_wave.size()] !== 1'b1) begin bad++; $display("FAIL rand%0d_tail: got %b want 1", it, txlog[st+exp_wave.size()]); end
        end
    endtask

    task automatic test_overflow_irq();
        logic [31:0] d;
        logic [7:0] b;
        int st, k;
        wait_idle(100);
        bus_write(A_DIV, 32'd200);
        bus_write(A_PAR, 32'd0);
        bus_write(A_STOP, 32'd0);
        bus_write(A_DBITS, 32'd3);
        exp_wave.delete();
        st = 0;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            if (n < DEPTH + 1) model_frame(b, 200, 1'b0, 1'b0, 3);
            bus_write(A_DATA, {24'd0, b});
            if (n == 0) st = last_widx + 1;
        end
        bus_read(A_LEVEL, d);
        total++; if (d !== 32'(DEPTH)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", d, DEPTH); end
        bus_read(A_STAT, d);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL ovf_status: got %b want 101", d[2:0]); end
        bus_write(A_STAT, 32'd0);
        bus_read(A_STAT, d);
        total++; if (d !== 32'd4) begin bad++; $display("FAIL ovf_clear: got %b want 100", d[2:0]); end
        bus_write(A_DIV, 32'd8);
        bus_read(A_DIV, d);
        total++; if (d !== 32'd200) begin bad++; $display("FAIL cfg_lock: got %0d want 200", d); end
        bus_write(A_IRQ, 32'h0000_0101);
        bus_read(A_IRQ, d);
        total++; if (d !== 32'h0000_0101) begin bad++; $display("FAIL irq_reg: got %h want 101", d); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq_o); end
        k = 0;
        while (irq_o !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1 after %0d cycles", irq_o, k); end
        bus_read(A_LEVEL, d);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL irq_level: got %0d want 1", d); end
        wait_log(st + exp_wave.size() + 1, 20000);
        for (int i = 0; i < exp_wave.size(); i++) begin
            total++;
            if (txlog[st+i] !== exp_wave[i]) begin bad++; $display("FAIL ovf_wave[%0d]: got %b want %b", i, txlog[st+i], exp_wave[i]); end
        end
        total++;
        if (txlog[st+exp_wave.size()] !== 1'b1) begin bad++; $display("FAIL ovf_tail (10th byte sent?): got %b want 1", txlog[st+exp_wave.size()]); end
    endtask

    task automatic test_soft_reset();
        logic [31:0] d;
        int st, w;
        wait_idle(1000);
        bus_write(A_DIV, 32'd4);
        bus_write(A_PAR, 32'd1);
        bus_write(A_DBITS, 32'd3);
        bus_write(A_DATA, 32'h00);
        st = last_widx + 1;
        bus_write(A_DATA, 32'h00);
        wait_log(st + 8, 100);
        bus_read(A_DIV, d);
        total++; if (d !== 32'd4) begin bad++; $display("FAIL srst_pre_div: got %0d want 4", d); end
        bus_write(A_RST, 32'd1);
        w = last_widx;
        total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL srst_mid_data: got %b want 0", tx_o); end
        @(posedge clk);
        #1;
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL srst_tx: got %b want 1", tx_o); end
        total++; if (read_data_o !== 32'd4) begin bad++; $display("FAIL srst_rdata_kept: got %0d want 4", read_data_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL srst_irq: got %b want 0", irq_o); end
        wait_log(w + 12, 100);
        for (int i = 1; i < 12; i++) begin
            total++;
            if (txlog[w+i] !== 1'b1) begin bad++; $display("FAIL srst_line[%0d]: got %b want 1", i, txlog[w+i]); end
        end
        bus_read(A_LEVEL, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL srst_level: got %0d want 0", d); end
        bus_read(A_STAT, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL srst_status: got %b want 010", d[2:0]); end
        bus_read(A_DIV, d);
        total++; if (d !== 32'(DEF_DIV)) begin bad++; $display("FAIL srst_div: got %0d want %0d", d, DEF_DIV); end
        bus_read(A_IRQ, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL srst_irqreg: got %h want 0", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int st;
        wait_idle(100);
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'h00);
        st = last_widx + 1;
        bus_write(A_DATA, 32'h00);
        wait_log(st + 8, 100);
        bus_read(A_DIV, d);
        @(posedge clk);
        #3;
        total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL arst_mid_data: got %b want 0", tx_o); end
        rstn_i = 1'b0;
        #1;
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL arst_tx: got %b want 1", tx_o); end
        total++; if (read_data_o !== 32'd0) begin bad++; $display("FAIL arst_rdata: got %h want 0", read_data_o); end
        @(negedge clk);
        rstn_i = 1'b1;
        bus_read(A_LEVEL, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL arst_level: got %0d want 0", d); end
        bus_read(A_DIV, d);
        total++; if (d !== 32'(DEF_DIV)) begin bad++; $display("FAIL arst_div: got %0d want %0d", d, DEF_DIV); end
        bus_read(A_BUSY, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL arst_busy: got %0d want 0", d); end
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL arst_idle_tx: got %b want 1", tx_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random();
        test_overflow_irq();
        test_soft_reset();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
